// File: rtl/d_e_issue_reg_if.sv
// D->E issue boundary signals: decoded D-stage fields in, registered E-stage fields
// and hazard/stall status out.
interface d_e_issue_reg_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic [WIDTH-1:0] D_PC, D_Instr, D_RD1, D_RD2, D_EXT;
  logic [4:0]       D_A3;
  logic             D_isMD;
  logic [2:0]       D_MDUop;
  logic             D_HIWrite, D_LOWrite, D_HIRead, D_LORead;
  logic             stall_other, flush, E_busy;

  logic [WIDTH-1:0] E_PC, E_Instr, E_RD1, E_RD2, E_EXT;
  logic [4:0]       E_A3;
  logic             E_start;
  logic [2:0]       E_MDUop;
  logic             E_HIWrite, E_LOWrite, E_HIRead, E_LORead;
  logic             D_stall, md_wait;
  logic [CNT_W-1:0] md_stall_cnt;

  modport master (
    output D_PC, D_Instr, D_RD1, D_RD2, D_EXT, D_A3, D_isMD, D_MDUop,
           D_HIWrite, D_LOWrite, D_HIRead, D_LORead, stall_other, flush, E_busy,
    input  E_PC, E_Instr, E_RD1, E_RD2, E_EXT, E_A3, E_start, E_MDUop,
           E_HIWrite, E_LOWrite, E_HIRead, E_LORead, D_stall, md_wait, md_stall_cnt
  );

  modport slave (
    input  D_PC, D_Instr, D_RD1, D_RD2, D_EXT, D_A3, D_isMD, D_MDUop,
           D_HIWrite, D_LOWrite, D_HIRead, D_LORead, stall_other, flush, E_busy,
    output E_PC, E_Instr, E_RD1, E_RD2, E_EXT, E_A3, E_start, E_MDUop,
           E_HIWrite, E_LOWrite, E_HIRead, E_LORead, D_stall, md_wait, md_stall_cnt
  );
endinterface

// File: rtl/d_e_issue_reg.sv
// D/E pipeline register in front of the MDU: issues the one-cycle MDU start,
// stalls D on MDU structural hazards and counts those stall cycles.
module d_e_issue_reg #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input logic         clk,
  input logic         reset,
  d_e_issue_reg_if.slave bus
);
  localparam logic [0:0] RUN    = 1'b0;
  localparam logic [0:0] MDWAIT = 1'b1;

  typedef struct packed {
    logic [WIDTH-1:0] pc, instr, rd1, rd2, ext;
    logic [4:0]       a3;
    logic             start;
    logic [2:0]       mduop;
    logic             hiw, low, hir, lor;
  } e_reg_t;

  e_reg_t           e_q, e_d;
  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             d_uses_md, md_hz, d_stall;

  assign d_uses_md = bus.D_isMD | bus.D_HIWrite | bus.D_LOWrite | bus.D_HIRead | bus.D_LORead;
  assign md_hz     = d_uses_md & bus.E_busy;
  assign d_stall   = md_hz | bus.stall_other;

  // A stalled D never enters E, so start fires exactly once per MD instruction.
  always_comb begin
    e_d = '0;
    if (!(bus.flush | d_stall)) begin
      e_d.pc    = bus.D_PC;
      e_d.instr = bus.D_Instr;
      e_d.rd1   = bus.D_RD1;
      e_d.rd2   = bus.D_RD2;
      e_d.ext   = bus.D_EXT;
      e_d.a3    = bus.D_A3;
      e_d.start = bus.D_isMD;
      e_d.mduop = bus.D_MDUop;
      e_d.hiw   = bus.D_HIWrite;
      e_d.low   = bus.D_LOWrite;
      e_d.hir   = bus.D_HIRead;
      e_d.lor   = bus.D_LORead;
    end
  end

  always_comb begin
    state_d = md_hz ? MDWAIT : RUN;
    cnt_d   = cnt_q;
    if (md_hz && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_q     <= '0;
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      e_q     <= e_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.E_PC         = e_q.pc;
  assign bus.E_Instr      = e_q.instr;
  assign bus.E_RD1        = e_q.rd1;
  assign bus.E_RD2        = e_q.rd2;
  assign bus.E_EXT        = e_q.ext;
  assign bus.E_A3         = e_q.a3;
  assign bus.E_start      = e_q.start;
  assign bus.E_MDUop      = e_q.mduop;
  assign bus.E_HIWrite    = e_q.hiw;
  assign bus.E_LOWrite    = e_q.low;
  assign bus.E_HIRead     = e_q.hir;
  assign bus.E_LORead     = e_q.lor;
  assign bus.D_stall      = d_stall;
  assign bus.md_wait      = (state_q == MDWAIT);
  assign bus.md_stall_cnt = cnt_q;
endmodule

// File: doc/d_e_issue_reg.md
Name: d_e_issue_reg

Overview:
- D/E pipeline register of the P6 five-stage pipeline, sitting directly upstream of the E-stage multiply/divide unit (MDU).
- Latches decoded D-stage operands and control into E, generates the one-cycle MDU `start` pulse, and detects MDU structural hazards.
- On an MDU hazard it freezes F/D and inserts bubbles into E until the MDU is no longer busy.
- Keeps a saturating count of MDU-induced stall cycles for performance debug.

Parameters:
- WIDTH, 32, datapath width of PC/instruction/operand fields.
- CNT_W, 16, width of the MDU stall-cycle counter.

Ports:
- clk  in  1  the single pipeline clock.
- reset  in  1  asynchronous, active-low reset.
- D_PC  in  WIDTH  D-stage PC.
- D_Instr  in  WIDTH  D-stage instruction word.
- D_RD1  in  WIDTH  forwarded rs value.
- D_RD2  in  WIDTH  forwarded rt value.
- D_EXT  in  WIDTH  extended immediate.
- D_A3  in  5  destination GPR index (0 = none).
- D_isMD  in  1  instruction is mult/multu/div/divu.
- D_MDUop  in  3  0=mult, 1=multu, 2=div, 3=divu.
- D_HIWrite  in  1  mthi.
- D_LOWrite  in  1  mtlo.
- D_HIRead  in  1  mfhi.
- D_LORead  in  1  mflo.
- stall_other  in  1  non-MDU hazard stall from the hazard unit.
- flush  in  1  squash the instruction entering E.
- E_busy  in  1  MDU busy (already includes its own start).
- E_PC, E_Instr, E_RD1, E_RD2, E_EXT  out  WIDTH  registered copies of the D fields.
- E_A3  out  5  registered destination GPR index.
- E_start  out  1  MDU start pulse.
- E_MDUop  out  3  registered MDU operation.
- E_HIWrite, E_LOWrite, E_HIRead, E_LORead  out  1  registered HI/LO controls.
- D_stall  out  1  hold PC and F/D register.
- md_wait  out  1  FSM is in MDWAIT.
- md_stall_cnt  out  CNT_W  saturating count of MDU stall cycles.

Behaviour:
- The interface uses one clock; reset is asynchronous and active-low.
- Reset (reset==0), applied asynchronously and regardless of clk:
  - All E_* outputs are 0, which is a bubble: nop, A3=0, no start.
  - FSM goes to RUN.
  - md_stall_cnt is 0.
- Define `d_uses_md = D_isMD | D_HIWrite | D_LOWrite | D_HIRead | D_LORead`.
- MDU hazard is combinational: `md_hz = d_uses_md & E_busy`.
- Outputs derived from the hazard:
  - `D_stall = md_hz | stall_other`, combinational.
  - md_wait is registered (FSM state) and is not combinational.
- Register update at each posedge clk, in priority order:
  1. flush or D_stall: load a bubble (all E_* = 0).
  2. Otherwise load the D fields.
  - When the D fields are loaded, `E_start <= D_isMD`.
- E_start therefore lasts exactly one cycle per mult/div instruction. It is never re-asserted for the same instruction, because a stalled D never enters E twice.
- Simultaneous flush and stall: a bubble enters E. D is held, because D_stall still drives the upstream registers.
- FSM:
  - RUN -> MDWAIT when md_hz==1 at the clock edge.
  - MDWAIT -> RUN when md_hz==0 at the clock edge. This covers both busy dropping and the MD instruction leaving D.
  - MDWAIT -> MDWAIT while md_hz==1.
- Counter:
  - md_stall_cnt increments at each edge where md_hz==1.
  - It saturates at 2^CNT_W-1 and does not wrap.
  - stall_other cycles are not counted.
- MDU timing the block relies on:
  - busy is high in the start cycle plus 5 cycles for mult/multu, or plus 10 cycles for div/divu.
  - An HI/LO consumer in D waits 6 or 11 cycles respectively after the MD instruction enters E.
- Back-to-back MD instructions: the second one stalls while the first is busy. Its start is issued the cycle after busy falls.
- Non-MD instructions never stall on E_busy and flow through while the MDU computes.
- Reset asserted mid-stall: the FSM returns to RUN and the counter clears immediately (asynchronously), and E is a bubble.

Test Plan:
- Reset sequence: reset=0 mid-cycle with random inputs -> E_* all 0, md_stall_cnt=0 and md_wait=0 at once, without a clock edge.
- Single mult: D_isMD=1, D_MDUop=0, D_RD1=7, D_RD2=6, E_busy=0 -> next cycle E_start=1, E_MDUop=0, E_RD1=7, E_RD2=6; following cycle E_start=0.
- MDU hazard: mult enters E, then mfhi in D with E_busy high for 6 cycles -> D_stall=1 for 6 cycles, E bubble each cycle, md_wait=1, md_stall_cnt=6. mfhi reaches E on cycle 7 with E_HIRead=1.
- Independent instruction: addu in D (D_A3=5) while E_busy=1 -> D_stall=0, E_A3=5 next cycle, md_stall_cnt unchanged.
- Flush plus MD: D_isMD=1 and flush=1 -> E_start=0 and E_Instr=0 next cycle. With flush=1 and stall_other=1 together -> bubble, D_stall=1.
- Saturation: CNT_W=4, hold md_hz=1 for 20 cycles -> md_stall_cnt stops at 15, md_wait=1 throughout; drop E_busy -> md_wait=0 after the next edge.
